// File: rtl/uart_sched_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    GAP
  } sched_state_e;

  localparam int unsigned DEF_GAP_CYC     = 16;
  localparam int unsigned DEF_TIMEOUT_CYC = 65535;
  localparam int unsigned ID_W            = 3;

  // Next requester index after idx, wrapping at n-1.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx,
                                               input int unsigned     n);
    return (32'(idx) >= n - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  localparam int unsigned PW = ID_W + 1;

  logic [PW-1:0] pos;

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path through this block can infer a latch.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = PW'(ptr) + PW'(k);
      if (pos >= PW'(NUM_REQ)) pos = pos - PW'(NUM_REQ);
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!any && req[j] && pos == PW'(j)) begin
          grant[j] = 1'b1;
          idx      = ID_W'(j);
          any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one byte-wide UART transmitter among NUM_REQ requesters with round-robin,
// packet lock, a start/busy/clear handshake and a watchdog for a stuck transmitter.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned GAP_CYC     = DEF_GAP_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  input  logic                   tx_clear_req,
  output logic [2:0]             grant_id,
  output logic                   lock_active,
  output logic                   timeout_err
);

  sched_state_e       state;
  logic [ID_W-1:0]    rr_ptr;
  logic               last_q;
  logic [15:0]        wdog_cnt;
  logic [15:0]        gap_cnt;
  logic               busy_s1, busy_s2;
  logic               clr_s1, clr_s2, clr_s3;
  logic               clr_rise, wdog_hit, gap_done;
  logic [NUM_REQ-1:0] eligible, arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;
  logic [7:0]         sel_data;
  logic               sel_last;

  assign clr_rise = clr_s2 & ~clr_s3;
  assign wdog_hit = (wdog_cnt == 16'(TIMEOUT_CYC - 1));
  assign gap_done = (gap_cnt == 16'(GAP_CYC - 1));

  // While a packet is locked only its owner may be granted, whatever else is valid.
  assign eligible = lock_active ? (req_valid & (NUM_REQ'(1) << grant_id)) : req_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    sel_data = 8'h00;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_data = req_data[8*i +: 8];
        sel_last = req_last[i];
      end
    end
  end

  // NOTE: all state is assigned with <= so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      grant_id    <= '0;
      lock_active <= 1'b0;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
      last_q      <= 1'b0;
      wdog_cnt    <= '0;
      gap_cnt     <= '0;
      busy_s1     <= 1'b0;
      busy_s2     <= 1'b0;
      clr_s1      <= 1'b0;
      clr_s2      <= 1'b0;
      clr_s3      <= 1'b0;
    end else begin
      busy_s1     <= tx_busy;
      busy_s2     <= busy_s1;
      clr_s1      <= tx_clear_req;
      clr_s2      <= clr_s1;
      clr_s3      <= clr_s2;
      req_ready   <= '0;
      timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (arb_any) begin
            tx_data   <= sel_data;
            last_q    <= sel_last;
            req_ready <= arb_grant;
            grant_id  <= arb_idx;
            wdog_cnt  <= '0;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          wdog_cnt <= wdog_cnt + 16'd1;
          if (busy_s2) begin
            tx_start <= 1'b0;
            state    <= WAIT_DONE;
          end else if (wdog_hit) begin
            timeout_err <= 1'b1;
            tx_start    <= 1'b0;
            lock_active <= 1'b0;
            rr_ptr      <= wrap_inc(grant_id, NUM_REQ);
            state       <= IDLE;
          end else begin
            tx_start <= 1'b1;
          end
        end

        WAIT_DONE: begin
          wdog_cnt <= wdog_cnt + 16'd1;
          // A done edge on the watchdog's last cycle still counts as a clean finish.
          if (clr_rise) begin
            if (last_q) begin
              lock_active <= 1'b0;
              rr_ptr      <= wrap_inc(grant_id, NUM_REQ);
            end else begin
              lock_active <= 1'b1;
            end
            gap_cnt <= '0;
            state   <= (GAP_CYC == 0) ? IDLE : GAP;
          end else if (wdog_hit) begin
            timeout_err <= 1'b1;
            tx_start    <= 1'b0;
            lock_active <= 1'b0;
            rr_ptr      <= wrap_inc(grant_id, NUM_REQ);
            state       <= IDLE;
          end
        end

        GAP: begin
          if (gap_done) state <= IDLE;
          else          gap_cnt <= gap_cnt + 16'd1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomised scoreboard bench for uart_tx_scheduler with a behavioural transmitter
// and a queue-based arbitration model.
module tb_uart_tx_scheduler;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned GAP_CYC     = 3;
  localparam int unsigned TIMEOUT_CYC = 100;
  localparam int          BUDGET      = 3000;

  typedef enum int {M_NORMAL, M_STUCK, M_EXACT, M_HANG} tx_mode_e;
  typedef struct { logic [7:0] data; logic last; } pkt_t;
  typedef struct { int id; logic [7:0] data; logic last; logic lock_before; logic exp_to; } exp_t;

  logic                 wb_clk_i = 1'b0;
  logic                 wb_rst_i;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 tx_clear_req;
  logic [2:0]           grant_id;
  logic                 lock_active;
  logic                 timeout_err;

  uart_tx_scheduler #(
    .NUM_REQ     (NUM_REQ),
    .GAP_CYC     (GAP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .tx_clear_req (tx_clear_req),
    .grant_id     (grant_id),
    .lock_active  (lock_active),
    .timeout_err  (timeout_err)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
  endtask

  pkt_t     req_q[NUM_REQ][$];
  pkt_t     pend[NUM_REQ][$];
  exp_t     sb_q[$];
  tx_mode_e tx_mode_q[$];

  // Reference model state: rotation pointer and packet owner.
  int m_ptr   = 0;
  bit m_lock  = 0;
  int m_owner = 0;

  exp_t cur;
  bit   have_cur  = 0;
  bit   saw_to    = 0;
  bit   start_chk = 0;
  int   cyc       = 0;
  bit   tx_active = 0;
  bit   tx_abort  = 0;

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NUM_REQ; i++) s += req_q[i].size() + pend[i].size();
    return s;
  endfunction

  task automatic add_byte(input int id, input logic [7:0] d, input logic last);
    pkt_t p;
    p.data = d;
    p.last = last;
    pend[id].push_back(p);
  endtask

  // Predict the grant order of everything in pend[], then hand it to the requesters at once.
  task automatic load_batch(input tx_mode_e first_mode);
    pkt_t tmp[NUM_REQ][$];
    int   total = 0;
    bit   first = 1;
    for (int i = 0; i < NUM_REQ; i++) begin
      tmp[i] = pend[i];
      total += tmp[i].size();
    end
    while (total > 0) begin
      int   id;
      pkt_t p;
      exp_t e;
      id = -1;
      if (m_lock) id = m_owner;
      else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          int j;
          j = (m_ptr + k) % NUM_REQ;
          if (id < 0 && tmp[j].size() > 0) id = j;
        end
      end
      if (id < 0 || tmp[id].size() == 0) break;
      p = tmp[id].pop_front();
      total--;
      e.id          = id;
      e.data        = p.data;
      e.last        = p.last;
      e.lock_before = m_lock;
      e.exp_to      = first && (first_mode == M_STUCK);
      if (e.exp_to || p.last) begin
        m_lock = 0;
        m_ptr  = (id + 1) % NUM_REQ;
      end else begin
        m_lock  = 1;
        m_owner = id;
      end
      sb_q.push_back(e);
      tx_mode_q.push_back(first ? first_mode : M_NORMAL);
      first = 0;
    end
    @(negedge wb_clk_i);
    for (int i = 0; i < NUM_REQ; i++)
      while (pend[i].size() > 0) req_q[i].push_back(pend[i].pop_front());
  endtask

  task automatic close_item();
    if (have_cur) begin
      check("timeout_flag_last", saw_to, cur.exp_to);
      have_cur = 0;
    end
  endtask

  task automatic drain();
    int c = 0;
    while ((sb_q.size() != 0 || pending() != 0) && c < BUDGET) begin
      @(negedge wb_clk_i);
      c++;
    end
    repeat (3) @(negedge wb_clk_i);
    while (tx_active && c < BUDGET) begin
      @(negedge wb_clk_i);
      c++;
    end
    check("drain_in_budget", c < BUDGET, 1);
    repeat (GAP_CYC + 4) @(negedge wb_clk_i);
    close_item();
  endtask

  task automatic pulse_clear();
    tx_clear_req = 1'b1;
    tx_busy      = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    tx_clear_req = 1'b0;
  endtask

  initial begin : req_driver
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge wb_clk_i);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
        req_valid[i]       = (req_q[i].size() > 0);
        req_data[8*i +: 8] = req_valid[i] ? req_q[i][0].data : 8'h00;
        req_last[i]        = req_valid[i] ? req_q[i][0].last : 1'b0;
      end
    end
  end

  // Behavioural transmitter: one byte at a time, behaviour chosen per byte.
  initial begin : tx_model
    tx_mode_e    mode;
    int          n;
    logic [7:0]  data_cap;
    tx_busy      = 1'b0;
    tx_clear_req = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      if (tx_start && !wb_rst_i) begin
        mode      = (tx_mode_q.size() > 0) ? tx_mode_q.pop_front() : M_NORMAL;
        tx_active = 1;
        case (mode)
          M_NORMAL: begin
            repeat ($urandom_range(0, 3)) @(negedge wb_clk_i);
            tx_busy  = 1'b1;
            data_cap = tx_data;
            n = 0;
            while (tx_start && n < 20) begin
              @(negedge wb_clk_i);
              n++;
            end
            check("tx_start_release", tx_start, 0);
            repeat ($urandom_range(1, 4)) @(negedge wb_clk_i);
            check("tx_data_hold", tx_data, data_cap);
            pulse_clear();
          end
          M_STUCK: begin
            n = 0;
            while (tx_start && n < 300) begin
              @(negedge wb_clk_i);
              n++;
            end
          end
          M_EXACT: begin
            // tx_start was first seen one cycle after the grant; the clear edge is
            // timed so its synchronised rise lands on the watchdog's final cycle.
            @(negedge wb_clk_i);
            tx_busy = 1'b1;
            repeat (95) @(negedge wb_clk_i);
            pulse_clear();
          end
          default: begin
            tx_busy = 1'b1;
            n = 0;
            while (!tx_abort && n < 2000) begin
              @(negedge wb_clk_i);
              n++;
            end
            tx_busy = 1'b0;
          end
        endcase
        tx_active = 0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge wb_clk_i);
      if (!wb_rst_i) begin
        if (start_chk) begin
          check("tx_start_latency", tx_start, 1);
          start_chk = 0;
        end
        cyc++;
        if (timeout_err) begin
          check("timeout_expected", have_cur && cur.exp_to, 1);
          check("timeout_cycle", cyc, TIMEOUT_CYC);
          check("timeout_tx_start", tx_start, 0);
          saw_to = 1;
        end
        if (req_ready != '0) begin
          check("ready_onehot", $onehot(req_ready), 1);
          if (have_cur) check("timeout_flag", saw_to, cur.exp_to);
          if (sb_q.size() == 0) begin
            check("unexpected_grant", req_ready, 0);
            have_cur = 0;
          end else begin
            cur      = sb_q.pop_front();
            have_cur = 1;
            saw_to   = 0;
            cyc      = 0;
            check("ready_vec", req_ready, 1 << cur.id);
            check("grant_id", grant_id, cur.id);
            check("tx_data", tx_data, cur.data);
            check("lock_at_grant", lock_active, cur.lock_before);
            start_chk = 1;
          end
        end
      end
    end
  end

  initial begin : stim
    int c;
    wb_rst_i = 1'b1;
    repeat (4) @(negedge wb_clk_i);
    check("rst_req_ready", req_ready, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_lock", lock_active, 0);
    check("rst_timeout", timeout_err, 0);
    wb_rst_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);

    // Single byte
    add_byte(0, 8'h41, 1'b1);
    load_batch(M_NORMAL);
    drain();
    check("t1_lock_idle", lock_active, 0);

    // Round robin, all requesters valid
    add_byte(0, 8'h10, 1'b1);
    add_byte(1, 8'h11, 1'b1);
    add_byte(2, 8'h12, 1'b1);
    add_byte(3, 8'h13, 1'b1);
    add_byte(0, 8'h14, 1'b1);
    load_batch(M_NORMAL);
    drain();

    // Packet lock: three-byte packet from req0 while req1 keeps requesting
    add_byte(0, 8'hA0, 1'b0);
    add_byte(0, 8'hA1, 1'b0);
    add_byte(0, 8'hA2, 1'b1);
    add_byte(1, 8'hB0, 1'b1);
    add_byte(1, 8'hB1, 1'b1);
    load_batch(M_NORMAL);
    drain();
    check("t3_lock_released", lock_active, 0);

    // Watchdog: transmitter never goes busy on a mid-packet byte
    add_byte(0, 8'hC0, 1'b0);
    add_byte(1, 8'hC1, 1'b1);
    load_batch(M_STUCK);
    drain();
    check("t4_lock_after_timeout", lock_active, 0);

    // Reset while waiting for the transmitter to finish
    add_byte(0, 8'h5A, 1'b1);
    load_batch(M_HANG);
    c = 0;
    while ((sb_q.size() != 0 || !tx_busy) && c < BUDGET) begin
      @(negedge wb_clk_i);
      c++;
    end
    check("t5_reach_wait_done", c < BUDGET, 1);
    repeat (6) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check("t5_req_ready", req_ready, 0);
    check("t5_tx_start", tx_start, 0);
    check("t5_tx_data", tx_data, 0);
    check("t5_grant_id", grant_id, 0);
    check("t5_lock", lock_active, 0);
    check("t5_timeout", timeout_err, 0);
    wb_rst_i  = 1'b0;
    have_cur  = 0;
    start_chk = 0;
    m_ptr     = 0;
    m_lock    = 0;
    tx_abort  = 1;
    c = 0;
    while ((tx_busy || tx_active) && c < 100) begin
      @(negedge wb_clk_i);
      c++;
    end
    tx_abort = 0;
    repeat (4) @(negedge wb_clk_i);
    add_byte(0, 8'h77, 1'b1);
    load_batch(M_NORMAL);
    drain();

    // Done edge coincides with the watchdog limit
    add_byte(2, 8'hE2, 1'b1);
    add_byte(3, 8'hE3, 1'b1);
    load_batch(M_EXACT);
    drain();

    // Random packet mixes
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        int npk;
        npk = $urandom_range(0, 2);
        for (int p = 0; p < npk; p++) begin
          int len;
          len = $urandom_range(1, 3);
          for (int k = 0; k < len; k++) add_byte(i, 8'($urandom), k == len - 1);
        end
      end
      load_batch(M_NORMAL);
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : global_guard
    #800000;
    $display("FAIL global_timeout: got %0d checks, want completion", n_checks);
    $fatal(1, "simulation time limit");
  end

endmodule
